// File: rtl/xorshift32_prng.sv
// -----------------------------------------------------------------------------
// xorshift32_prng
//
// Purpose:
//   32-bit Marsaglia xorshift pseudo-random number generator. The generator
//   is free-running and produces one new 32-bit word on every rising clock
//   edge. The state register drives the output directly. The sampling logic
//   uses the low 16 bits as a uniform value.
//
// Ports:
//   clk_i     input   1   system clock, rising-edge active
//   reset_ni  input   1   asynchronous active-low reset (0 = reset asserted)
//   rand_o    output  32  current generator state / random word (registered)
//
// Parameters:
//   SEED      reset state. A value of 0 would lock the generator at 0, so it
//             is replaced by 32'h92D68CA2.
//   SHIFT_A   first left-shift amount  (1..31)
//   SHIFT_B   right-shift amount       (1..31)
//   SHIFT_C   second left-shift amount (1..31)
// -----------------------------------------------------------------------------
module xorshift32_prng #(
    parameter logic [31:0] SEED    = 32'h92D68CA2,
    parameter int          SHIFT_A = 13,
    parameter int          SHIFT_B = 17,
    parameter int          SHIFT_C = 5
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    output logic [31:0] rand_o
);

    localparam logic [31:0] DEFAULT_SEED = 32'h92D68CA2;

    // Zero is the one fixed point of the xorshift map, so a zero seed is
    // swapped for the default seed.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? DEFAULT_SEED : SEED;

    // Reject shift amounts outside 1..31 during elaboration.
    if ((SHIFT_A < 1) || (SHIFT_A > 31)) begin : g_bad_shift_a
        $error("xorshift32_prng: SHIFT_A must be in 1..31");
    end
    if ((SHIFT_B < 1) || (SHIFT_B > 31)) begin : g_bad_shift_b
        $error("xorshift32_prng: SHIFT_B must be in 1..31");
    end
    if ((SHIFT_C < 1) || (SHIFT_C > 31)) begin : g_bad_shift_c
        $error("xorshift32_prng: SHIFT_C must be in 1..31");
    end

    // One xorshift step. All three stages are evaluated in order within one
    // cycle. The shifts are logical on unsigned 32-bit values. Left shifts
    // drop bits above bit 31, and right shifts fill with zeros.
    function automatic logic [31:0] xs_step(input logic [31:0] s);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = s  ^ (s  << SHIFT_A);
        t2 = t1 ^ (t1 >> SHIFT_B);
        return t2 ^ (t2 << SHIFT_C);
    endfunction

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = xs_step(state_q);
    end

    // Asserting reset returns the state to the seed at once, without waiting
    // for a clock edge. After release, the first edge performs the first step.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign rand_o = state_q;

endmodule

// File: tb/tb_xorshift32_prng.sv
// -----------------------------------------------------------------------------
// tb_xorshift32_prng
//
// Self-checking bench. It uses three generator instances: the default seed,
// SEED=1, and SEED=0. All three share the clock and the reset. Before each
// clock edge, the bench advances a software xorshift32(13,17,5) model and
// pushes the expected words to a queue. After the edge, it pops the queue and
// compares the expected words with the outputs.
// -----------------------------------------------------------------------------
module tb_xorshift32_prng;

    localparam logic [31:0] DEF_SEED = 32'h92D68CA2;

    logic        clk;
    logic        reset_n;
    logic [31:0] rand_def;
    logic [31:0] rand_s1;
    logic [31:0] rand_s0;

    xorshift32_prng dut_def (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .rand_o   (rand_def)
    );

    xorshift32_prng #(.SEED(32'h00000001)) dut_s1 (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .rand_o   (rand_s1)
    );

    xorshift32_prng #(.SEED(32'h00000000)) dut_s0 (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .rand_o   (rand_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] s1;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [31:0] m_def;
    logic [31:0] m_s1;
    logic [31:0] first_def;
    int          idx;
    int          zero_cnt;
    int          low_cnt;

    // Reference xorshift32 with shifts 13, 17 and 5.
    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] a;
        a = s ^ (s << 13);
        a = a ^ (a >> 17);
        a = a ^ (a << 5);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Runs n clock cycles. Before each edge, the bench pushes the expected
    // words to the queue. After the edge, it pops them and checks the outputs.
    task automatic run_cycles(input int n, input bit restart_chk);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            m_def = model_step(m_def);
            m_s1  = model_step(m_s1);
            sb_q.push_back({m_def, m_s1});
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("seq_def", rand_def, e.d);
                chk("seq_s1",  rand_s1,  e.s1);
                chk("seq_s0",  rand_s0,  e.d);
            end
            if (idx == 0) begin
                chk("s1_step1", rand_s1, 32'h00042021);
                if (restart_chk) chk("restart_first", rand_def, first_def);
                else             first_def = rand_def;
            end
            if (idx == 1) chk("s1_step2", rand_s1, 32'h04080601);
            if (rand_def == 32'd0) zero_cnt++;
            if (rand_def[15:0] < 16'd16384) low_cnt++;
            idx++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        idx       = 0;
        zero_cnt  = 0;
        low_cnt   = 0;
        first_def = 32'd0;
        m_def     = DEF_SEED;
        m_s1      = 32'h00000001;
        reset_n   = 1'b0;

        // Hold reset for three cycles. All outputs must stay at their seeds.
        repeat (3) begin
            @(negedge clk);
            chk("rst_s1",  rand_s1,  32'h00000001);
            chk("rst_def", rand_def, DEF_SEED);
            chk("rst_s0",  rand_s0,  DEF_SEED);
        end

        // Release reset away from the clock edge. The seed is still held
        // until the first edge.
        reset_n = 1'b1;
        #1;
        chk("pre_edge_def", rand_def, DEF_SEED);
        chk("pre_edge_s1",  rand_s1,  32'h00000001);

        run_cycles(50, 1'b0);

        // Assert reset in the middle of a cycle. The state must return to
        // the seed without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_def", rand_def, DEF_SEED);
        chk("async_s1",  rand_s1,  32'h00000001);
        chk("async_s0",  rand_s0,  DEF_SEED);

        m_def    = DEF_SEED;
        m_s1     = 32'h00000001;
        idx      = 0;
        zero_cnt = 0;
        low_cnt  = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // This run restarts from reset. It checks every output against the
        // model, confirms the generator never reaches zero, and counts the
        // low 16-bit values below 16384.
        run_cycles(65536, 1'b1);

        chk("never_zero", zero_cnt, 0);
        if (low_cnt < 16384 - 600 || low_cnt > 16384 + 600)
            chk("low16_uniform", low_cnt, 16384);
        else
            chk("low16_uniform", 32'd1, 32'd1);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
